// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: FSM state encoding and the
// occupancy width. The state encoding doubles as the entry count.
// Optional build macro used by this slice: PIPE_STAGE_FLUSH_DATA_EN.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Entries held in each state.
  function automatic logic [OCC_W-1:0] occ_of(input state_t st);
    case (st)
      ST_ONE:  occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One instruction holding register: valid bit, control fields, data fields.
// Latency: load visible one cycle later. Backpressure: none, the owner decides.
// Ports: clk, rst_n (async active-low), load/in_ctrl/in_data write the slot;
//   clear kills valid and ctrl (clear_data additionally zeroes data);
//   valid/ctrl/data are the registered contents. clear wins over load.
module pipe_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      // Zeroed control fields make the slot read as a NOP bubble.
      valid <= 1'b0;
      ctrl  <= '0;
      if (clear_data) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register built as a two-slot skid buffer (main + skid).
// Latency: 1 cycle; 1 instruction/cycle while out_ready is high.
// Backpressure: in_ready is registered (= skid slot empty), so a downstream
// stall is absorbed by the skid slot without a combinational ready path.
// Ports: in_valid/in_ready/in_ctrl/in_data upstream handshake; out_valid/
//   out_ready/out_ctrl/out_data downstream handshake; flush kills everything
//   held (an input accepted in the flush cycle is dropped); occupancy = 0..2.
// Build macro PIPE_STAGE_FLUSH_DATA_EN: flush also zeroes the data fields;
//   by default data fields keep stale values on flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  state_t state, state_nxt;

  logic in_fire, out_fire;

  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;
  logic clear_data;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic [CTRL_W-1:0] main_in_ctrl;
  logic [DATA_W-1:0] main_in_data;

  // Both terms come straight from registers, so in_ready never sees
  // out_ready or flush combinationally.
  assign in_ready  = ~skid_valid;
  assign occupancy = occ_of(state);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

`ifdef PIPE_STAGE_FLUSH_DATA_EN
  assign clear_data = flush;
`else
  assign clear_data = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_nxt = ST_FULL;
          else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Slot control outputs
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      // An out_fire this cycle has already been taken downstream; an
      // in_fire is simply not captured.
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = in_fire;
        ST_ONE: begin
          if (in_fire && out_fire) main_load = 1'b1;
          else if (in_fire)        skid_load = 1'b1;
          else if (out_fire)       main_clear = 1'b1; // keep bubble ctrl at zero
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_in_data = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (main_load),
    .clear      (main_clear),
    .clear_data (clear_data),
    .in_ctrl    (main_in_ctrl),
    .in_data    (main_in_data),
    .valid      (out_valid),
    .ctrl       (out_ctrl),
    .data       (out_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .clear_data (clear_data),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .valid      (skid_valid),
    .ctrl       (skid_ctrl),
    .data       (skid_data)
  );

endmodule
